// File: rtl/proj001_sched_pkg.sv
// Shared types and widths for the proj001 job scheduler.
// The operand word is viewed as a nibble vector so nibble k is data[k].
package proj001_sched_pkg;
  localparam int NIBBLE_W = 4;
  localparam int OP_W     = 2;
  localparam int RES_W    = 5;
  localparam int NIBBLES  = 4;
  localparam int DATA_W   = NIBBLE_W * NIBBLES;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] nib_vec_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    nib_vec_t        data;
  } job_t;
endpackage

// File: rtl/proj001_sched_rr_arbiter2.sv
// Two-way round-robin pick; the requester that did not win last time has priority.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic hit,
  output logic win
);
  assign hit = req0 | req1;
  assign win = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/proj001_sched.sv
// Shares one proj001 datapath between two requesters: arbitrate, stream four
// operand nibbles, wait (bounded) for dp_valid, and return the result to the winner.
module proj001_sched
  import proj001_sched_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                req0,
  input  logic [OP_W-1:0]     op0,
  input  logic [DATA_W-1:0]   data0,
  input  logic                req1,
  input  logic [OP_W-1:0]     op1,
  input  logic [DATA_W-1:0]   data1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                done0,
  output logic                done1,
  output logic [RES_W-1:0]    result,
  output logic                err,
  output logic                busy,
  output logic                dp_capture,
  output logic [NIBBLE_W-1:0] dp_d_in,
  output logic [OP_W-1:0]     dp_op,
  input  logic                dp_valid,
  input  logic [RES_W-1:0]    dp_result
);
  localparam int NIB_IDX_W = $clog2(NIBBLES);
  localparam int CNT_W     = NIB_IDX_W + 1;
  localparam int WC_W      = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NIBBLES);
  localparam logic [WC_W-1:0]  WC_END  = WC_W'(TIMEOUT - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [WC_W-1:0]    wcnt, wcnt_nx;
  logic               last, last_nx;
  logic               owner, owner_nx;
  job_t               job, job_nx;
  job_t               in0, in1;

  logic               gnt0_nx, gnt1_nx, done0_nx, done1_nx;
  logic [RES_W-1:0]   result_nx;
  logic               err_nx, busy_nx, cap_nx;
  logic [NIBBLE_W-1:0] din_nx;
  logic [OP_W-1:0]    op_nx;
  logic               arb_hit, arb_win;

  assign in0 = {op0, data0};
  assign in1 = {op1, data1};

  rr_arbiter2 u_arb (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .hit  (arb_hit),
    .win  (arb_win)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wcnt_nx   = wcnt;
    last_nx   = last;
    owner_nx  = owner;
    job_nx    = job;
    gnt0_nx   = 1'b0;
    gnt1_nx   = 1'b0;
    done0_nx  = 1'b0;
    done1_nx  = 1'b0;
    result_nx = result;
    err_nx    = err;
    cap_nx    = dp_capture;
    din_nx    = dp_d_in;
    op_nx     = dp_op;
    case (state)
      IDLE: begin
        if (arb_hit) begin
          owner_nx = arb_win;
          last_nx  = arb_win;
          job_nx   = arb_win ? in1 : in0;
          gnt0_nx  = ~arb_win;
          gnt1_nx  = arb_win;
          op_nx    = job_nx.op;
          cap_nx   = 1'b1;
          din_nx   = job_nx.data[0];
          cnt_nx   = CNT_W'(1);
          state_nx = LOAD;
        end
      end
      LOAD: begin
        // dp_valid is deliberately not looked at until the last nibble is out
        if (cnt == CNT_END) begin
          cap_nx   = 1'b0;
          wcnt_nx  = '0;
          state_nx = WAIT;
        end else begin
          cap_nx = 1'b1;
          din_nx = job.data[cnt[NIB_IDX_W-1:0]];
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT: begin
        // valid is checked first so it wins over a coincident timeout
        if (dp_valid) begin
          result_nx = dp_result;
          err_nx    = 1'b0;
          done0_nx  = ~owner;
          done1_nx  = owner;
          state_nx  = IDLE;
        end else if (wcnt == WC_END) begin
          result_nx = '0;
          err_nx    = 1'b1;
          done0_nx  = ~owner;
          done1_nx  = owner;
          state_nx  = IDLE;
        end else begin
          wcnt_nx = wcnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wcnt       <= '0;
      last       <= 1'b1;
      owner      <= 1'b0;
      job        <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      result     <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      dp_capture <= 1'b0;
      dp_d_in    <= '0;
      dp_op      <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      wcnt       <= wcnt_nx;
      last       <= last_nx;
      owner      <= owner_nx;
      job        <= job_nx;
      gnt0       <= gnt0_nx;
      gnt1       <= gnt1_nx;
      done0      <= done0_nx;
      done1      <= done1_nx;
      result     <= result_nx;
      err        <= err_nx;
      busy       <= busy_nx;
      dp_capture <= cap_nx;
      dp_d_in    <= din_nx;
      dp_op      <= op_nx;
    end
  end
endmodule

// File: tb/tb_proj001_sched.sv
// Bench for proj001_sched: a job-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized client/datapath traffic.
module tb_proj001_sched;
  import proj001_sched_pkg::*;
  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic [15:0] data0 = '0, data1 = '0;
  logic        dp_valid = 1'b0;
  logic [4:0]  dp_result = '0;
  logic        gnt0, gnt1, done0, done1, err, busy, dp_capture;
  logic [4:0]  result;
  logic [3:0]  dp_d_in;
  logic [1:0]  dp_op;

  always #5 clock = ~clock;

  proj001_sched #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .rst(rst),
    .req0(req0), .op0(op0), .data0(data0),
    .req1(req1), .op1(op1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .err(err), .busy(busy),
    .dp_capture(dp_capture), .dp_d_in(dp_d_in), .dp_op(dp_op),
    .dp_valid(dp_valid), .dp_result(dp_result)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a job is described by its age in cycles since the grant edge.
  // Ages 0..3 carry nibble <age>, age 4 ends loading, ages 5..4+TIMEOUT are wait edges.
  bit         m_busy = 0, m_win = 0, m_last = 1;
  int         m_age = 0;
  logic [15:0] m_data = '0;
  logic [1:0] m_op = '0;
  logic       e_gnt0 = 0, e_gnt1 = 0, e_done0 = 0, e_done1 = 0, e_err = 0, e_busy = 0, e_cap = 0;
  logic [4:0] e_result = '0;
  logic [3:0] e_din = '0;
  logic [1:0] e_op = '0;

  initial begin
    forever begin
      @(posedge clock or posedge rst);
      if (rst) begin
        m_busy = 0; m_last = 1; m_age = 0;
        e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0; e_err = 0; e_busy = 0;
        e_cap = 0; e_result = '0; e_din = '0; e_op = '0;
      end else begin
        e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0;
        if (!m_busy) begin
          if (req0 || req1) begin
            m_win  = (req0 && req1) ? !m_last : req1;
            m_last = m_win;
            m_data = m_win ? data1 : data0;
            m_op   = m_win ? op1 : op0;
            e_gnt0 = !m_win; e_gnt1 = m_win;
            m_busy = 1; m_age = 0;
            e_op = m_op; e_cap = 1; e_din = m_data[3:0];
          end
        end else begin
          m_age++;
          if (m_age < NIBBLES) e_din = m_data[m_age*4 +: 4];
          else if (m_age == NIBBLES) e_cap = 0;
          else if (dp_valid || m_age == NIBBLES + TIMEOUT) begin
            e_result = dp_valid ? dp_result : 5'd0;
            e_err    = !dp_valid;
            e_done0  = !m_win; e_done1 = m_win;
            m_busy   = 0;
          end
        end
        e_busy = m_busy;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clock);
      vectors++;
      if ({gnt0, gnt1, done0, done1, result, err, busy, dp_capture, dp_d_in, dp_op} !==
          {e_gnt0, e_gnt1, e_done0, e_done1, e_result, e_err, e_busy, e_cap, e_din, e_op}) begin
        miscompares++;
        $display("FAIL cycle_compare t=%0t dut g%b%b d%b%b res=%h err=%b busy=%b cap=%b din=%h op=%h | model g%b%b d%b%b res=%h err=%b busy=%b cap=%b din=%h op=%h",
                 $time, gnt0, gnt1, done0, done1, result, err, busy, dp_capture, dp_d_in, dp_op,
                 e_gnt0, e_gnt1, e_done0, e_done1, e_result, e_err, e_busy, e_cap, e_din, e_op);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output bit which);
    int n = 0;
    do begin tick(); n++; end while (!(gnt0 || gnt1) && n < 64);
    if (!(gnt0 || gnt1)) chk("wait_gnt_timeout", 0, 1);
    which = gnt1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin tick(); n++; end while (!(done0 || done1) && n < 64);
    if (!(done0 || done1)) chk("wait_done_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  bit w;
  int n;

  initial begin
    #1 rst = 1'b1;
    tick();
    chk("reset_outputs", {gnt0, gnt1, done0, done1, result, err, busy, dp_capture, dp_d_in, dp_op}, 0);
    tick(); rst = 1'b0; tick();

    // single job
    req0 = 1; data0 = 16'h4321; op0 = 2'b01;
    tick();
    chk("t1_gnt0", gnt0, 1); chk("t1_cap", dp_capture, 1);
    chk("t1_din0", dp_d_in, 1); chk("t1_op", dp_op, 2'b01);
    req0 = 0;
    for (int k = 1; k < 4; k++) begin
      tick();
      if (k == 1) chk("t1_gnt_pulse", gnt0, 0);
      chk("t1_din", dp_d_in, k + 1); chk("t1_cap_on", dp_capture, 1);
    end
    tick(); chk("t1_cap_off", dp_capture, 0); chk("t1_busy", busy, 1);
    tick();
    dp_valid = 1; dp_result = 5'h0A;
    tick();
    chk("t1_done0", done0, 1); chk("t1_result", result, 5'h0A);
    chk("t1_err", err, 0); chk("t1_busy_fall", busy, 0);
    dp_valid = 0;

    // contention: strict alternation over four jobs
    do_reset();
    data0 = 16'h1111; op0 = 2'b10; data1 = 16'h2222; op1 = 2'b11;
    dp_valid = 1; dp_result = 5'h07;
    for (int j = 0; j < 4; j++) begin
      req0 = 1; req1 = 1;
      wait_gnt(w);
      chk("t2_winner", w, j % 2);
      if (w) req1 = 0; else req0 = 0;
      wait_done(n);
      chk("t2_done_owner", done1, w);
    end
    req0 = 0; req1 = 0; dp_valid = 0;
    tick();

    // timeout
    req0 = 1; data0 = 16'h9A5C; op0 = 2'b00;
    wait_gnt(w); req0 = 0;
    wait_done(n);
    chk("t3_len", n, NIBBLES + TIMEOUT);
    chk("t3_err", err, 1); chk("t3_result", result, 0); chk("t3_busy", busy, 0);
    tick();

    // valid during LOAD ignored, then valid coincident with last wait edge
    req1 = 1; data1 = 16'hBEEF; op1 = 2'b11;
    wait_gnt(w); req1 = 0;
    dp_valid = 1; dp_result = 5'h1F;
    tick(); dp_valid = 0;
    chk("t4_load_valid_ignored", done1, 0);
    for (int i = 0; i < 18; i++) begin
      tick(); chk("t4_no_early_done", done1, 0);
    end
    dp_valid = 1; dp_result = 5'h15;
    tick();
    chk("t4_done1", done1, 1); chk("t4_err", err, 0); chk("t4_result", result, 5'h15);
    dp_valid = 0;
    tick();

    // reset in the middle of LOAD
    req0 = 1; data0 = 16'h7654; op0 = 2'b10;
    wait_gnt(w); req0 = 0;
    tick();
    #2 rst = 1;
    #1 chk("t5_async_clear", {gnt0, gnt1, done0, done1, result, err, busy, dp_capture, dp_d_in, dp_op}, 0);
    tick(); tick(); rst = 0;
    req0 = 1; req1 = 1;
    wait_gnt(w);
    chk("t5_post_reset_winner", w, 0);
    req0 = 0; req1 = 0;
    dp_valid = 1;
    wait_done(n);
    dp_valid = 0;
    tick();

    // back-to-back regrant with req1 held
    req1 = 1; data1 = 16'h0F1E; op1 = 2'b01; dp_valid = 1; dp_result = 5'h11;
    wait_gnt(w);
    for (int j = 0; j < 3; j++) begin
      data1 = 16'($urandom); op1 = 2'($urandom);
      wait_done(n);
      chk("t6_done1", done1, 1);
      tick();
      chk("t6_regrant", gnt1, 1);
    end
    req1 = 0; dp_valid = 0;
    wait_done(n);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (gnt0) req0 = 0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1; data0 = 16'($urandom); op0 = 2'($urandom);
      end
      if (gnt1) req1 = 0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1; data1 = 16'($urandom); op1 = 2'($urandom);
      end
      dp_valid  = ($urandom_range(0, 11) == 0);
      dp_result = 5'($urandom);
      tick();
    end
    req0 = 0; req1 = 0; dp_valid = 0;
    for (int c = 0; c < 30; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
